// File: rtl/tqvp_rebeccargb_display_scanner_pkg.sv
// tqvp_rebeccargb_display_scanner_pkg: register map, control field positions and scan geometry
package tqvp_rebeccargb_display_scanner_pkg;
   localparam logic [3:0] ADDR_STAGE0 = 4'd0;
   localparam logic [3:0] ADDR_STAGE1 = 4'd1;
   localparam logic [3:0] ADDR_STAGE2 = 4'd2;
   localparam logic [3:0] ADDR_STAGE3 = 4'd3;
   localparam logic [3:0] ADDR_CTRL   = 4'd4;
   localparam logic [3:0] ADDR_DIV_LO = 4'd5;
   localparam logic [3:0] ADDR_DIV_HI = 4'd6;
   localparam logic [3:0] ADDR_CMD    = 4'd7;
   localparam logic [3:0] ADDR_DISP   = 4'd8;
   localparam int CTRL_EN  = 7;
   localparam int CTRL_DAL = 6;
   localparam int CTRL_L   = 4;
   localparam int CTRL_B   = 0;
   localparam logic [7:0] CTRL_RESET = 8'h3F;
   localparam int PHASES     = 16;
   localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/tqvp_rebeccargb_display_scanner_display_scan_timer.sv
// display_scan_timer: prescaler plus phase/digit counters for the display scanner
module display_scan_timer
   import tqvp_rebeccargb_display_scanner_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] div,
   input  logic [1:0]  last,
   output logic        tick,
   output logic [3:0]  phase,
   output logic [1:0]  cur,
   output logic        frame_wrap
);
   logic [15:0] pc;
   assign tick = en && pc == div;
   // cur > last (L lowered mid-slot) also wraps, so the slot always completes
   assign frame_wrap = tick && phase == 4'(PHASES - 1) && cur >= last;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc    <= '0;
         phase <= '0;
         cur   <= '0;
      end else if (!en) begin
         pc    <= '0;
         phase <= '0;
         cur   <= '0;
      end else begin
         pc <= tick ? '0 : pc + 16'd1;
         if (tick) begin
            phase <= phase + 4'd1;
            if (phase == 4'(PHASES - 1)) cur <= cur >= last ? '0 : cur + 2'd1;
         end
      end
endmodule

// File: rtl/tqvp_rebeccargb_display_scanner.sv
// tqvp_rebeccargb_display_scanner: double-buffered 4-digit segment scanner with PWM brightness
module tqvp_rebeccargb_display_scanner
   import tqvp_rebeccargb_display_scanner_pkg::*;
#(
   parameter logic [15:0] RESET_DIV = 16'd63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [7:0] seg_out,
   output logic [3:0] dig_out,
   output logic       frame_tick
);
   logic [7:0]  staging [NUM_DIGITS];
   logic [7:0]  display [NUM_DIGITS];
   logic [7:0]  ctrl;
   logic [15:0] div;
   logic        pend;
   logic        tick, frame_wrap, en, dal, lit, commit;
   logic [3:0]  phase, bright;
   logic [1:0]  cur, last;
   assign en     = ctrl[CTRL_EN];
   assign dal    = ctrl[CTRL_DAL];
   assign last   = ctrl[CTRL_L +: 2];
   assign bright = ctrl[CTRL_B +: 4];
   // phase 0 is the ghost guard between digits
   assign lit    = en && phase != 4'd0 && phase <= bright;
   assign commit = frame_wrap && cur == last && pend;
   display_scan_timer timer (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div       (div),
      .last      (last),
      .tick      (tick),
      .phase     (phase),
      .cur       (cur),
      .frame_wrap(frame_wrap)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            staging[i] <= '0;
            display[i] <= '0;
         end
         ctrl       <= CTRL_RESET;
         div        <= RESET_DIV;
         pend       <= 1'b0;
         seg_out    <= '0;
         dig_out    <= '0;
         frame_tick <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (data_write && address == 4'(i)) staging[i] <= data_in;
            if (commit) display[i] <= staging[i];
            dig_out[i] <= (lit && cur == 2'(i)) ? ~dal : dal;
         end
         if (data_write && address == ADDR_CTRL) ctrl <= data_in;
         if (data_write && address == ADDR_DIV_LO) div[7:0] <= data_in;
         if (data_write && address == ADDR_DIV_HI) div[15:8] <= data_in;
         // a commit write coinciding with the copy keeps pend set for the next frame
         pend       <= (data_write && address == ADDR_CMD) || (pend && !commit);
         seg_out    <= display[cur];
         frame_tick <= frame_wrap;
      end
   always_comb begin
      data_out = '0;
      case (address)
         ADDR_STAGE0: data_out = staging[0];
         ADDR_STAGE1: data_out = staging[1];
         ADDR_STAGE2: data_out = staging[2];
         ADDR_STAGE3: data_out = staging[3];
         ADDR_CTRL:   data_out = ctrl;
         ADDR_DIV_LO: data_out = div[7:0];
         ADDR_DIV_HI: data_out = div[15:8];
         ADDR_CMD:    data_out = {pend, en, cur, phase};
         ADDR_DISP:   data_out = display[cur];
         default:     data_out = '0;
      endcase
   end
endmodule

// File: tb/tb_tqvp_rebeccargb_display_scanner.sv
// tb_tqvp_rebeccargb_display_scanner: randomized scan configurations against an arithmetic tick-count model
module tb_tqvp_rebeccargb_display_scanner;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] address = '0;
   logic       data_write = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out, seg_out;
   logic [3:0] dig_out;
   logic       frame_tick;
   int checks = 0;
   int failures = 0;

   tqvp_rebeccargb_display_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .address   (address),
      .data_write(data_write),
      .data_in   (data_in),
      .data_out  (data_out),
      .seg_out   (seg_out),
      .dig_out   (dig_out),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] v);
      @(negedge clk);
      address = a;
      data_in = v;
      data_write = 1'b1;
      @(negedge clk);
      data_write = 1'b0;
   endtask

   // strobes expected after t prescaler ticks since enable
   function automatic logic [3:0] exp_dig(int t, int l, int b, bit dal);
      logic [3:0] r;
      int ph = t % 16;
      int c = (t / 16) % (l + 1);
      for (int i = 0; i < 4; i++) r[i] = (ph != 0 && ph <= b && i == c) ? !dal : dal;
      return r;
   endfunction

   initial begin
      logic [7:0] disp_old [4];
      logic [7:0] stg [4];
      logic [7:0] es;
      int d, l, b, fr, t, tp, n;
      bit dal;
      for (int k = 0; k < 4; k++) disp_old[k] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_seg", seg_out, 0);
      chk("rst_dig", dig_out, 0);
      chk("rst_frame", frame_tick, 0);
      for (int a = 0; a < 10; a++) begin
         address = 4'(a);
         #1;
         chk($sformatf("rst_reg%0d", a), data_out, (a == 4 || a == 5) ? 16'h3F : 16'h0);
      end

      for (int it = 0; it < 6; it++) begin
         d = $urandom_range(0, 3);
         l = $urandom_range(0, 3);
         b = $urandom_range(0, 15);
         dal = 1'($urandom_range(0, 1));
         fr = 16 * (l + 1);
         for (int k = 0; k < 4; k++) begin
            stg[k] = 8'($urandom);
            wr(4'(k), stg[k]);
         end
         wr(4'd5, 8'(d));
         wr(4'd6, 8'h00);
         wr(4'd7, 8'h00);
         wr(4'd4, {1'b1, dal, 2'(l), 4'(b)});
         address = 4'd7;
         for (int m = 1; m <= 2 * fr * (d + 1) + 3; m++) begin
            @(negedge clk);
            #1;
            tp = (m - 1) / (d + 1);
            t = m / (d + 1);
            es = tp >= fr ? stg[(tp / 16) % (l + 1)] : disp_old[(tp / 16) % (l + 1)];
            chk("scan_seg", seg_out, es);
            chk("scan_dig", dig_out, exp_dig(tp, l, b, dal));
            chk("scan_frame", frame_tick, (m % (d + 1) == 0 && t % fr == 0) ? 1 : 0);
            chk("scan_reg7", data_out, {t < fr, 1'b1, 2'((t / 16) % (l + 1)), 4'(t % 16)});
         end
         wr(4'd4, 8'h3F);
         for (int k = 0; k < 4; k++) disp_old[k] = stg[k];
      end

      wr(4'd5, 8'h00);
      wr(4'd6, 8'h00);
      wr(4'd4, 8'hBF);
      address = 4'd7;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (data_out[5:4] != 2'd2 && n < 200);
      chk("lchg_reach_cur2", data_out[5:4], 2);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (data_out[3:0] != 4'd5 && n < 20);
      chk("lchg_reach_ph5", data_out[3:0], 5);
      wr(4'd4, 8'h8F);
      address = 4'd7;
      #1;
      n = 0;
      while (data_out[5:4] == 2'd2 && n < 40) begin @(negedge clk); #1; n++; end
      chk("lchg_cur", data_out[5:4], 0);
      chk("lchg_phase", data_out[3:0], 0);
      chk("lchg_frame", frame_tick, 1);
      repeat (20) @(negedge clk);
      #1;
      chk("lchg_stay0", data_out[5:4], 0);

      wr(4'd4, 8'hBF);
      wr(4'd0, 8'h77);
      repeat (80) @(negedge clk);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (dig_out != 4'b0001 && n < 80);
      chk("dbuf_old_seg", seg_out, disp_old[0]);
      wr(4'd7, 8'h00);
      address = 4'd7;
      #1;
      chk("dbuf_pend", data_out[7], 1);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (frame_tick != 1'b1 && n < 100);
      chk("dbuf_frame_seen", frame_tick, 1);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (dig_out != 4'b0001 && n < 80);
      chk("dbuf_new_seg", seg_out, 8'h77);
      chk("dbuf_pend_clr", data_out[7], 0);

      wr(4'd4, 8'hFF);
      repeat (5) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_seg", seg_out, 0);
      chk("arst_dig", dig_out, 0);
      chk("arst_frame", frame_tick, 0);
      address = 4'd5;
      #1;
      chk("arst_div", data_out, 8'h3F);
      address = 4'd4;
      #1;
      chk("arst_ctrl", data_out, 8'h3F);
      address = 4'd0;
      #1;
      chk("arst_stage0", data_out, 0);
      @(negedge clk);
      rst = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
